// File: rtl/text_seq_core_pkg.sv
// Shared types for the text sequencer core.
// Holds the opcode and FSM state encodings plus the opcode field width.
package text_core_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_RESET   = 3'd0,
        OP_LOAD    = 3'd1,
        OP_STORE   = 3'd2,
        OP_ADVANCE = 3'd3,
        OP_INCR    = 3'd4,
        OP_PAUSE   = 3'd5,
        OP_SETPTR  = 3'd6,
        OP_JUMP    = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        LOAD_WB = 3'd3,
        EXEC    = 3'd4,
        PAUSE   = 3'd5
    } state_t;

endpackage

// File: rtl/text_seq_core_if.sv
// Single-port memory bus between the sequencer core and its memory.
// master: addr, wr_data, wr_en out, rd_data in; slave: the reverse.
interface text_seq_core_if #(
    parameter int DW = 16,
    parameter int AW = 16
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [DW-1:0] rd_data;

    modport master (
        output addr,
        output wr_data,
        output wr_en,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  wr_en,
        output rd_data
    );

endinterface

// File: rtl/text_seq_core_pause.sv
// Pause timer: counts cycles spent in PAUSE, re-armed by clear.
// Ports: clk, rst_n, clear, enable in; done out (count==PAUSE_CYCLES-1).
module tc_pause_timer #(
    parameter int PAUSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(PAUSE_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CW'(PAUSE_CYCLES - 1));

endmodule

// File: rtl/text_seq_core.sv
// Multicycle fetch/decode/execute sequencer driving a text-window pointer.
// Ports: clk, rst_n, run in; halted out; bus (master) to shared memory.
module text_seq_core
    import text_core_pkg::*;
#(
    parameter int          DW           = 16,
    parameter int          AW           = 16,
    parameter int          TEXT_BASE    = 914,
    parameter int          WRAP_AT      = 8000,
    parameter int          WRAP_TO      = 895,
    parameter int unsigned INC_STEP     = 32'h0301,
    parameter int          PAUSE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            halted,
    text_seq_core_if.master bus
);

    localparam int IW = DW - OPW;

    localparam logic [AW-1:0] BASE  = AW'(TEXT_BASE);
    localparam logic [AW-1:0] W_AT  = AW'(WRAP_AT);
    localparam logic [AW-1:0] W_TO  = AW'(WRAP_TO);
    localparam logic [DW-1:0] STEP  = DW'(INC_STEP);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] data_q, data_d;
    opcode_t       op_q, op_d;
    logic [IW-1:0] imm_q, imm_d;

    opcode_t       dec_op;
    logic [AW-1:0] imm_ext;
    state_t        bound;
    logic          pt_clear;
    logic          pt_en;
    logic          pt_done;

    assign dec_op  = opcode_t'(bus.rd_data[OPW-1:0]);
    assign imm_ext = AW'(imm_q);
    assign bound   = run ? FETCH : IDLE;
    assign halted  = (state_q == IDLE);

    tc_pause_timer #(
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_pause (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pt_clear),
        .enable (pt_en),
        .done   (pt_done)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        op_d        = op_q;
        imm_d       = imm_q;
        pt_clear    = 1'b0;
        pt_en       = 1'b0;
        bus.addr    = pc_q;
        bus.wr_data = '0;
        bus.wr_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                pc_d  = pc_q + 1'b1;
                op_d  = dec_op;
                imm_d = bus.rd_data[DW-1:OPW];
                unique case (dec_op)
                    OP_LOAD: begin
                        bus.addr = ptr_q;
                        state_d  = LOAD_WB;
                    end
                    OP_STORE: begin
                        bus.addr    = ptr_q;
                        bus.wr_data = data_q;
                        bus.wr_en   = 1'b1;
                        state_d     = EXEC;
                    end
                    OP_PAUSE: begin
                        pt_clear = 1'b1;
                        state_d  = PAUSE;
                    end
                    default: begin
                        state_d = EXEC;
                    end
                endcase
            end
            LOAD_WB: begin
                data_d  = bus.rd_data;
                state_d = bound;
            end
            EXEC: begin
                // RESET and JUMP override the increment done in DECODE
                unique case (1'b1)
                    (op_q == OP_RESET):  pc_d = '0;
                    (op_q == OP_JUMP):   pc_d = imm_ext;
                    (op_q == OP_INCR):   data_d = data_q + STEP;
                    (op_q == OP_SETPTR): ptr_d = BASE + imm_ext;
                    (op_q == OP_ADVANCE):
                        ptr_d = (ptr_q == W_AT) ? W_TO : ptr_q + 1'b1;
                    default: ;
                endcase
                state_d = bound;
            end
            PAUSE: begin
                pt_en = 1'b1;
                if (pt_done) begin
                    state_d = bound;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ptr_q   <= BASE;
            data_q  <= '0;
            op_q    <= OP_RESET;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
        end
    end

endmodule

// File: tb/tb_text_seq_core.sv
// Scoreboard bench for text_seq_core: expected writes are queued by the
// stimulus, a monitor pops and checks them as the core writes memory.
module tb_text_seq_core;

    typedef struct {
        int a;
        int d;
        int dt;
    } exp_t;

    localparam int RST = 0, LD = 1, ST = 2, ADV = 3;
    localparam int INC = 4, PS = 5, SP = 6, JMP = 7;

    logic clk = 1'b0;
    logic rst_n, rst1_n, run, run1;
    logic halted0, halted1;
    logic ld_en;
    logic [15:0] ld_a, ld_d;
    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last0 = 0;
    int last1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_seq_core_if #(.DW(16), .AW(16)) b0 ();
    text_seq_core_if #(.DW(16), .AW(16)) b1 ();

    text_seq_core #(.PAUSE_CYCLES(4)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .halted (halted0),
        .bus    (b0)
    );

    text_seq_core #(.PAUSE_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst1_n),
        .run    (run1),
        .halted (halted1),
        .bus    (b1)
    );

    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_a] <= ld_d;
            mem1[ld_a] <= ld_d;
        end else begin
            if (b0.wr_en) mem0[b0.addr] <= b0.wr_data;
            if (b1.wr_en) mem1[b1.addr] <= b1.wr_data;
        end
        b0.rd_data <= mem0[b0.addr];
        b1.rd_data <= mem1[b1.addr];
    end

    function automatic void chk(input string nm, input int act,
                                input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     nm, act, act, req, req);
        end
    endfunction

    function automatic logic [15:0] ins(input int op, input int imm);
        return 16'((imm << 3) | op);
    endfunction

    always @(negedge clk) begin : mon0
        exp_t e;
        if (b0.wr_en) begin
            if (q0.size() == 0) begin
                chk("wr0_unexpected_addr", int'(b0.addr), -1);
            end else begin
                e = q0.pop_front();
                chk("wr0_addr", int'(b0.addr), e.a);
                chk("wr0_data", int'(b0.wr_data), e.d);
                if (e.dt >= 0) chk("wr0_gap", cyc - last0, e.dt);
                last0 = cyc;
            end
        end else if (b0.wr_data != 16'h0) begin
            chk("wr0_idle_data", int'(b0.wr_data), 0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (b1.wr_en) begin
            if (q1.size() == 0) begin
                chk("wr1_unexpected_addr", int'(b1.addr), -1);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", int'(b1.addr), e.a);
                chk("wr1_data", int'(b1.wr_data), e.d);
                if (e.dt >= 0) chk("wr1_gap", cyc - last1, e.dt);
                last1 = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_a  = 16'(a);
        ld_d  = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) poke(i, 16'h0);
    endtask

    task automatic prep0();
        run   = 1'b0;
        rst_n = 1'b0;
        tick();
        clear_prog();
    endtask

    task automatic go0();
        rst_n = 1'b1;
        tick();
        run = 1'b1;
    endtask

    task automatic push0(input int a, input int d, input int dt);
        exp_t e;
        e.a = a; e.d = d; e.dt = dt;
        q0.push_back(e);
    endtask

    task automatic push1(input int a, input int d, input int dt);
        exp_t e;
        e.a = a; e.d = d; e.dt = dt;
        q1.push_back(e);
    endtask

    task automatic drain(input int w);
        int n = 0;
        while (((w == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain%0d_timeout: %0d writes still pending, required 0",
                     w, (w == 0) ? q0.size() : q1.size());
            if (w == 0) q0.delete();
            else q1.delete();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        run    = 1'b0;
        run1   = 1'b0;
        ld_en  = 1'b0;
        ld_a   = '0;
        ld_d   = '0;
        tick();
        tick();
        chk("rst_halted", int'(halted0), 1);
        chk("rst_addr", int'(b0.addr), 0);
        chk("rst_wr_en", int'(b0.wr_en), 0);
        chk("rst_wr_data", int'(b0.wr_data), 0);

        // store/increment loop
        clear_prog();
        poke(0, ins(INC, 0));
        poke(1, ins(ST, 0));
        poke(2, ins(RST, 0));
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_halted", int'(halted0), 1);
        chk("idle_addr", int'(b0.addr), 0);
        chk("idle_wr_en", int'(b0.wr_en), 0);
        push0(914, 16'h0301, -1);
        push0(914, 16'h0602, 9);
        push0(914, 16'h0903, 9);
        run = 1'b1;
        tick();
        chk("fetch_halted", int'(halted0), 0);
        chk("fetch_addr", int'(b0.addr), 0);
        drain(0);

        // jump then halt mid-instruction
        prep0();
        poke(0, ins(SP, 100));
        poke(1, ins(JMP, 5));
        poke(5, ins(ST, 0));
        poke(6, ins(RST, 0));
        push0(1014, 0, -1);
        push0(1014, 0, 12);
        go0();
        drain(0);
        run = 1'b0;
        tick();
        chk("halt_halted", int'(halted0), 1);
        chk("halt_pc", int'(b0.addr), 6);
        repeat (3) tick();
        chk("halt_stay", int'(halted0), 1);
        chk("halt_pc_stay", int'(b0.addr), 6);

        // pointer wrap and plain advance
        prep0();
        poke(0, ins(INC, 0));
        poke(1, ins(SP, 7086));
        poke(2, ins(ADV, 0));
        poke(3, ins(ST, 0));
        poke(4, ins(SP, 7087));
        poke(5, ins(ADV, 0));
        poke(6, ins(ST, 0));
        poke(7, ins(JMP, 7));
        push0(895, 16'h0301, -1);
        push0(8002, 16'h0301, 9);
        go0();
        drain(0);

        // load then store, store then load
        prep0();
        poke(914, 16'hABCD);
        poke(0, ins(LD, 0));
        poke(1, ins(ADV, 0));
        poke(2, ins(ST, 0));
        poke(3, ins(SP, 10));
        poke(4, ins(INC, 0));
        poke(5, ins(ST, 0));
        poke(6, ins(INC, 0));
        poke(7, ins(LD, 0));
        poke(8, ins(ADV, 0));
        poke(9, ins(ST, 0));
        poke(10, ins(JMP, 10));
        push0(915, 16'hABCD, -1);
        push0(924, 16'hAECE, 9);
        push0(925, 16'hAECE, 12);
        go0();
        drain(0);

        // pause re-arm, PAUSE_CYCLES=4 and 1 side by side
        prep0();
        poke(0, ins(ST, 0));
        poke(1, ins(PS, 0));
        poke(2, ins(ST, 0));
        poke(3, ins(PS, 0));
        poke(4, ins(PS, 0));
        poke(5, ins(ST, 0));
        poke(6, ins(JMP, 6));
        push0(914, 0, -1);
        push0(914, 0, 9);
        push0(914, 0, 15);
        push1(914, 0, -1);
        push1(914, 0, 6);
        push1(914, 0, 9);
        rst1_n = 1'b1;
        go0();
        run1 = 1'b1;
        drain(0);
        drain(1);
        run1 = 1'b0;

        // reset asserted in PAUSE
        prep0();
        poke(0, ins(PS, 0));
        poke(1, ins(JMP, 0));
        go0();
        repeat (4) tick();
        chk("pause_busy", int'(halted0), 0);
        chk("pause_addr", int'(b0.addr), 1);
        rst_n = 1'b0;
        #1;
        chk("pause_rst_halted", int'(halted0), 1);
        chk("pause_rst_addr", int'(b0.addr), 0);
        chk("pause_rst_wr_en", int'(b0.wr_en), 0);

        // reset asserted during a STORE write
        prep0();
        poke(0, ins(INC, 0));
        poke(1, ins(SP, 50));
        poke(2, ins(ST, 0));
        poke(3, ins(JMP, 0));
        go0();
        repeat (8) tick();
        chk("st_wr_en", int'(b0.wr_en), 1);
        chk("st_addr", int'(b0.addr), 964);
        chk("st_data", int'(b0.wr_data), 16'h0301);
        rst_n = 1'b0;
        #1;
        chk("st_rst_wr_en", int'(b0.wr_en), 0);
        chk("st_rst_wr_data", int'(b0.wr_data), 0);
        chk("st_rst_addr", int'(b0.addr), 0);
        chk("st_rst_halted", int'(halted0), 1);
        run = 1'b0;
        clear_prog();
        poke(0, ins(ST, 0));
        poke(1, ins(JMP, 1));
        push0(914, 0, -1);
        go0();
        drain(0);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
